// File: rtl/cym_pkg.sv
// Shared types and helpers for the cymometer measurement sequencer.
package cym_pkg;

    localparam int unsigned RANGE_W = 2;
    localparam int unsigned TMR_W   = 26;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RETRY_W = 2;

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(3);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GATE = 3'd1,
        WAIT = 3'd2,
        EVAL = 3'd3,
        PUB  = 3'd4,
        HOLD = 3'd5
    } state_e;

    // Payload handed to the display path.
    typedef struct packed {
        logic [CNT_W-1:0]   cnt;
        logic [RANGE_W-1:0] rng;
        logic               nosig;
    } result_t;

    function automatic logic [TMR_W-1:0] gate_len(
        input logic [RANGE_W-1:0] rng,
        input logic [TMR_W-1:0]   g0,
        input logic [TMR_W-1:0]   g1,
        input logic [TMR_W-1:0]   g2,
        input logic [TMR_W-1:0]   g3
    );
        case (rng)
            2'd0:    return g0;
            2'd1:    return g1;
            2'd2:    return g2;
            default: return g3;
        endcase
    endfunction

endpackage

// File: rtl/cym_down_timer.sv
// Loadable down-counter that parks at zero; zero flag is registered alongside the count.
module cym_down_timer
    import cym_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/cym_meas_ctrl.sv
// Measurement sequencer: gate generation, auto-ranging, no-signal timeout and
// result publication with a display hold time.
module cym_meas_ctrl
    import cym_pkg::*;
#(
    parameter logic [TMR_W-1:0] GATE0    = 26'd500_000,
    parameter logic [TMR_W-1:0] GATE1    = 26'd5_000_000,
    parameter logic [TMR_W-1:0] GATE2    = 26'd25_000_000,
    parameter logic [TMR_W-1:0] GATE3    = 26'd50_000_000,
    parameter logic [TMR_W-1:0] TIMEOUT  = 26'd50_000_000,
    parameter logic [TMR_W-1:0] HOLD_CYC = 26'd25_000_000,
    parameter logic [CNT_W-1:0] LO_TH    = 32'd1000,
    parameter logic [CNT_W-1:0] HI_TH    = 32'd1_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               single,
    output logic               gate_out,
    input  logic               core_done,
    input  logic [CNT_W-1:0]   core_cnt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_cnt,
    output logic [RANGE_W-1:0] res_range,
    output logic               res_nosig,
    output logic               busy
);

    state_e               state_q, state_d;
    logic [RANGE_W-1:0]   range_q, range_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    result_t              res_q, res_d;
    logic                 valid_q, valid_d;
    logic                 gate_q;
    logic                 busy_q;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_zero;

    logic                 cnt_low;
    logic                 cnt_high;
    logic                 can_retry;
    logic [RANGE_W-1:0]   range_up;
    logic [RANGE_W-1:0]   range_dn;

    // One timer serves GATE, WAIT and HOLD; those phases never overlap.
    cym_down_timer u_timer (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign cnt_low   = (cnt_q < LO_TH);
    assign cnt_high  = (cnt_q >= HI_TH);
    assign can_retry = (retry_q < RETRY_MAX);
    assign range_up  = range_q + RANGE_W'(1);
    assign range_dn  = range_q - RANGE_W'(1);

    always_comb begin
        state_d  = state_q;
        range_d  = range_q;
        retry_d  = retry_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (en || single) begin
                    state_d  = GATE;
                    retry_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = gate_len(range_q, GATE0, GATE1, GATE2, GATE3) - TMR_W'(1);
                end
            end
            GATE: begin
                if (tmr_zero) begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT - TMR_W'(1);
                end
            end
            WAIT: begin
                // A completion pulse in the expiry cycle still counts as a result.
                if (core_done) begin
                    cnt_d   = core_cnt;
                    state_d = EVAL;
                end else if (tmr_zero) begin
                    res_d.cnt   = '0;
                    res_d.rng   = range_q;
                    res_d.nosig = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = PUB;
                end
            end
            EVAL: begin
                if (cnt_low && (range_q != '1) && can_retry) begin
                    range_d  = range_up;
                    retry_d  = retry_q + RETRY_W'(1);
                    state_d  = GATE;
                    tmr_load = 1'b1;
                    tmr_val  = gate_len(range_up, GATE0, GATE1, GATE2, GATE3) - TMR_W'(1);
                end else if (cnt_high && (range_q != '0) && can_retry) begin
                    range_d  = range_dn;
                    retry_d  = retry_q + RETRY_W'(1);
                    state_d  = GATE;
                    tmr_load = 1'b1;
                    tmr_val  = gate_len(range_dn, GATE0, GATE1, GATE2, GATE3) - TMR_W'(1);
                end else begin
                    res_d.cnt   = cnt_q;
                    res_d.rng   = range_q;
                    res_d.nosig = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = PUB;
                end
            end
            PUB: begin
                if (res_ready) begin
                    valid_d  = 1'b0;
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_CYC - TMR_W'(1);
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    if (en) begin
                        state_d  = GATE;
                        retry_d  = '0;
                        tmr_load = 1'b1;
                        tmr_val  = gate_len(range_q, GATE0, GATE1, GATE2, GATE3) - TMR_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            range_q <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            range_q <= range_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            gate_q  <= (state_d == GATE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign gate_out  = gate_q;
    assign res_valid = valid_q;
    assign res_cnt   = res_q.cnt;
    assign res_range = res_q.rng;
    assign res_nosig = res_q.nosig;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cym_meas_ctrl.sv
// Directed bench for cym_meas_ctrl with a cycle-level observable model checked every cycle.
module tb_cym_meas_ctrl;

    localparam int TOUT  = 30;
    localparam int HOLDC = 5;
    localparam int LO    = 100;
    localparam int HI    = 1000;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        en        = 1'b0;
    logic        single    = 1'b0;
    logic        core_done = 1'b0;
    logic [31:0] core_cnt  = '0;
    logic        res_ready = 1'b0;
    logic        gate_out;
    logic        res_valid;
    logic [31:0] res_cnt;
    logic [1:0]  res_range;
    logic        res_nosig;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cym_meas_ctrl #(
        .GATE0    (26'd10),
        .GATE1    (26'd20),
        .GATE2    (26'd40),
        .GATE3    (26'd80),
        .TIMEOUT  (26'd30),
        .HOLD_CYC (26'd5),
        .LO_TH    (32'd100),
        .HI_TH    (32'd1000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .single    (single),
        .gate_out  (gate_out),
        .core_done (core_done),
        .core_cnt  (core_cnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_cnt   (res_cnt),
        .res_range (res_range),
        .res_nosig (res_nosig),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int glen(input int r);
        case (r)
            0:       return 10;
            1:       return 20;
            2:       return 40;
            default: return 80;
        endcase
    endfunction

    // Observable-behaviour model: what phase the sequencer is in and how many visible cycles remain.
    typedef enum int {M_IDLE, M_GATE, M_WAIT, M_DECIDE, M_PUB, M_HOLD} mph_e;
    mph_e ph      = M_IDLE;
    int   left    = 0;
    int   m_range = 0;
    int   m_retry = 0;
    int   m_cnt   = 0;
    int   e_cnt   = 0;
    int   e_rng   = 0;
    int   e_nos   = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            ph      = M_IDLE;
            m_range = 0;
            m_retry = 0;
            check("rst_gate", gate_out, 0);
            check("rst_valid", res_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_cnt", res_cnt, 0);
            check("rst_range", res_range, 0);
            check("rst_nosig", res_nosig, 0);
        end else begin
            check("mon_gate", gate_out, ph == M_GATE);
            check("mon_valid", res_valid, ph == M_PUB);
            check("mon_busy", busy, ph != M_IDLE);
            if (ph == M_PUB) begin
                check("mon_res_cnt", res_cnt, e_cnt);
                check("mon_res_range", res_range, e_rng);
                check("mon_res_nosig", res_nosig, e_nos);
            end
            case (ph)
                M_IDLE: begin
                    if (en || single) begin
                        ph = M_GATE; left = glen(m_range); m_retry = 0;
                    end
                end
                M_GATE: begin
                    left--;
                    if (left == 0) begin ph = M_WAIT; left = TOUT; end
                end
                M_WAIT: begin
                    if (core_done) begin
                        m_cnt = int'(core_cnt); ph = M_DECIDE;
                    end else begin
                        left--;
                        if (left == 0) begin
                            e_cnt = 0; e_rng = m_range; e_nos = 1; ph = M_PUB;
                        end
                    end
                end
                M_DECIDE: begin
                    if (m_retry < 3 && m_cnt < LO && m_range < 3) begin
                        m_range++; m_retry++; ph = M_GATE; left = glen(m_range);
                    end else if (m_retry < 3 && m_cnt >= HI && m_range > 0) begin
                        m_range--; m_retry++; ph = M_GATE; left = glen(m_range);
                    end else begin
                        e_cnt = m_cnt; e_rng = m_range; e_nos = 0; ph = M_PUB;
                    end
                end
                M_PUB: begin
                    if (res_ready) begin ph = M_HOLD; left = HOLDC; end
                end
                M_HOLD: begin
                    left--;
                    if (left == 0) begin
                        if (en) begin
                            ph = M_GATE; left = glen(m_range); m_retry = 0;
                        end else begin
                            ph = M_IDLE;
                        end
                    end
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    // Counts high cycles of the next gate; 'started' means the current negedge already shows it high.
    task automatic measure_gate(input bit started, output int len);
        int g;
        g   = 0;
        len = 0;
        if (!started) begin
            do begin @(negedge sys_clk); g++; end while (!gate_out && g < 1000);
        end
        while (gate_out && g < 1000) begin
            len++;
            @(negedge sys_clk);
            g++;
        end
    endtask

    task automatic respond(input int cnt, input int dly);
        repeat (dly) @(posedge sys_clk);
        #2 core_done = 1'b1; core_cnt = 32'(cnt);
        @(posedge sys_clk);
        #2 core_done = 1'b0; core_cnt = '0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(negedge sys_clk);
            lat++;
        end
        check("valid_seen", res_valid, 1);
    endtask

    task automatic accept();
        @(posedge sys_clk);
        #2 res_ready = 1'b1;
        @(posedge sys_clk);
        #2 res_ready = 1'b0;
    endtask

    task automatic pulse_single();
        @(posedge sys_clk);
        #2 single = 1'b1;
        @(posedge sys_clk);
        #2 single = 1'b0;
    endtask

    task automatic check_res(input string tag, input int c, input int r, input int n);
        check({tag, "_cnt"}, res_cnt, c);
        check({tag, "_range"}, res_range, r);
        check({tag, "_nosig"}, res_nosig, n);
    endtask

    initial begin
        int len;
        int lat;
        int hc;
        int g;

        repeat (3) @(posedge sys_clk);
        check("init_gate", gate_out, 0);
        check("init_busy", busy, 0);
        #2 sys_rst = 1'b0; en = 1'b1;

        // 1: first gate at range 0, in-range count publishes
        measure_gate(1'b0, len);   check("t1_gate_len", len, 10);
        respond(500, 3);
        wait_valid(lat);           check_res("t1", 500, 0, 0);
        accept();
        @(posedge sys_clk);
        #2 core_done = 1'b1; core_cnt = 32'd7;
        @(posedge sys_clk);
        #2 core_done = 1'b0; core_cnt = '0;

        // 2: low count lengthens the gate, nothing published in between
        measure_gate(1'b0, len);   check("t2_gate_len0", len, 10);
        respond(50, 3);
        measure_gate(1'b0, len);   check("t2_gate_len1", len, 20);
        respond(400, 3);
        wait_valid(lat);           check_res("t2", 400, 1, 0);
        accept();

        // 3: high count shortens the gate
        measure_gate(1'b0, len);   check("t3_gate_len1", len, 20);
        respond(5000, 3);
        measure_gate(1'b0, len);   check("t3_gate_len0", len, 10);
        respond(600, 3);
        wait_valid(lat);           check_res("t3", 600, 0, 0);
        accept();

        // 4: timeout at range 1 reports no signal 30 cycles after gate fall
        measure_gate(1'b0, len);   check("t4_gate_len0", len, 10);
        respond(50, 3);
        measure_gate(1'b0, len);   check("t4_gate_len1", len, 20);
        wait_valid(lat);           check("t4_timeout_lat", lat, 30);
        check_res("t4", 0, 1, 1);
        accept();

        // 5: back-pressure keeps result stable, then exactly 5 hold cycles
        measure_gate(1'b0, len);   check("t5_gate_len_kept", len, 20);
        respond(300, 3);
        wait_valid(lat);           check_res("t5", 300, 1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            check("t5_stall_valid", res_valid, 1);
            check("t5_stall_cnt", res_cnt, 300);
            check("t5_stall_gate", gate_out, 0);
        end
        accept();
        @(negedge sys_clk);
        check("t5_valid_drop", res_valid, 0);
        hc = 0;
        g  = 0;
        while (!gate_out && g < 100) begin
            hc++;
            @(negedge sys_clk);
            g++;
        end
        check("t5_hold_cycles", hc, 5);

        // 6: alternating counts, retry limit forces publication on the 4th count
        measure_gate(1'b1, len);   check("t6_gate_a", len, 20);
        respond(50, 3);
        measure_gate(1'b0, len);   check("t6_gate_b", len, 40);
        respond(5000, 3);
        measure_gate(1'b0, len);   check("t6_gate_c", len, 20);
        respond(50, 3);
        measure_gate(1'b0, len);   check("t6_gate_d", len, 40);
        respond(5000, 3);
        wait_valid(lat);           check_res("t6", 5000, 2, 0);
        accept();

        g = 0;
        while (!gate_out && g < 100) begin @(negedge sys_clk); g++; end
        repeat (15) @(negedge sys_clk);
        check("t6_mid_gate", gate_out, 1);
        #1 sys_rst = 1'b1;
        #1;
        check("t6_async_gate", gate_out, 0);
        check("t6_async_busy", busy, 0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        @(posedge sys_clk);
        #2 en = 1'b0;

        // range cleared by reset; en dropped mid-measurement still completes
        measure_gate(1'b0, len);   check("t7_gate_after_rst", len, 10);
        pulse_single();
        respond(2000, 3);
        wait_valid(lat);           check_res("t7", 2000, 0, 0);
        accept();
        repeat (12) @(negedge sys_clk);
        check("t7_idle_busy", busy, 0);
        check("t7_idle_gate", gate_out, 0);

        // single-shot run; count equal to the low threshold is in range
        pulse_single();
        measure_gate(1'b0, len);   check("t8_gate_len0", len, 10);
        respond(99, 3);
        measure_gate(1'b0, len);   check("t8_gate_len1", len, 20);
        respond(100, 3);
        wait_valid(lat);           check_res("t8", 100, 1, 0);
        accept();
        repeat (10) @(negedge sys_clk);
        check("t8_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
